reg_file_bank: RTL and testbench
================================

Name: reg_file_bank

Overview:
- Register-file end of the register-select interface: consumes the eight active-low output-enable strobes and eight active-low load strobes from the register selector.
- Loads selected registers from the data bus on the clock edge.
- Drives the selected register onto the data bus.
- Register PC_INDEX doubles as the program counter, with a microsequencer-driven increment.
- Flags non-one-hot strobe patterns as sticky conflict errors for the bench and for debug.

Parameters:
WIDTH, 16, data bus and register width in bits
PC_INDEX, 7, index of the register that supports increment (program counter)
RESET_PC, 0, reset value of register PC_INDEX (all other registers reset to 0)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
regNotOEs  input  8  active-low output enables, bit i selects register i
regNotLoads  input  8  active-low load strobes, bit i selects register i
dataIn  input  WIDTH  data bus value to be loaded
pcInc  input  1  increment register PC_INDEX this cycle
errClear  input  1  clear sticky conflict flags
dataOut  output  WIDTH  bus drive value (combinational)
busDriven  output  1  high when any regNotOEs bit is 0 (combinational)
oeConflict  output  1  sticky: more than one OE ever active since reset/clear
loadConflict  output  1  sticky: more than one load ever active since reset/clear
dbgSel  input  3  debug register index
dbgData  output  WIDTH  contents of register dbgSel (combinational)

Behaviour:
- Reset (rising edge with reset=1): registers 0..7 <= 0 except register PC_INDEX <= RESET_PC; oeConflict <= 0; loadConflict <= 0. Reset overrides loads, pcInc and conflict detection in that cycle.
- dataOut is the bitwise OR of all registers whose regNotOEs bit is 0, which models a wired-OR bus.
  - No OE active: dataOut = 0 and busDriven = 0.
  - dataOut reflects current register contents in the same cycle, with zero latency.
- Load: at a rising edge, every register i with regNotLoads[i]=0 takes dataIn. Latency is one edge; the new value is visible on dataOut/dbgData after the edge.
  - Multiple loads active: all selected registers load dataIn.
- Read and load of the same register in one cycle: dataOut shows the old value, and the register takes dataIn at the edge. dataIn is not forwarded.
- pcInc: at an edge, register PC_INDEX <= register PC_INDEX + 1, modulo 2^WIDTH (0xFFFF wraps to 0x0000).
  - Load of PC_INDEX and pcInc in the same cycle: load wins and the increment is dropped.
- oeConflict: set at an edge when more than one regNotOEs bit is 0.
- loadConflict: set at an edge when more than one regNotLoads bit is 0.
- Both conflict flags stay set until reset or errClear. If errClear coincides with a new conflict, the flag stays set (set wins).
- One-hot or all-ones strobe patterns never set a conflict flag.
- Strobe inputs with X/Z are not supported. The bench drives only 0/1.

Decomposition:
- Shared package/globals header holds WIDTH default, register count (8), PC_INDEX default, and an inline popcount-greater-than-one function used by both conflict detectors.
- One natural sub-module: reg_cell (WIDTH-bit register with synchronous reset value, load enable, optional increment enable), instantiated 8 times.
- Increment enable is tied low except at PC_INDEX.
- Bus OR-reduction and conflict flags live at top level.

Test Plan:
- Reset with dataIn=0xBEEF and all loads active → all registers 0, PC=RESET_PC, both flags 0, busDriven=0, dataOut=0.
- regNotLoads=~(1<<3), dataIn=0x1234 for one edge, then regNotOEs=~(1<<3) → dataOut=0x1234, busDriven=1; dbgSel=3 shows 0x1234, and other registers read 0.
- Load PC=0xFFFE, then pcInc for 2 edges → PC 0xFFFF then 0x0000. Next, assert load PC with dataIn=0x0100 and pcInc in the same cycle → PC=0x0100.
- Registers 1=0x00F0, 2=0x0F00; regNotOEs=8'hF9 → dataOut=0x0FF0, oeConflict=1 after the edge. Then regNotOEs=8'hFF → oeConflict stays 1. errClear pulse → oeConflict=0.
- regNotLoads=8'h3F with dataIn=0xA5A5 → registers 6 and 7 both = 0xA5A5, loadConflict=1. errClear together with regNotLoads=8'hFC → loadConflict remains 1.
- Register 4=0x5555: regNotOEs=~(1<<4), regNotLoads=~(1<<4), dataIn=0xAAAA → dataOut=0x5555 before the edge, 0xAAAA after. Reset asserted mid-sequence → register 4=0 on the next edge.

Source files
------------

// File: rtl/reg_file_bank_pkg.sv
// Shared constants and helpers for the register-file bank.
// Both strobe-conflict detectors use the popcount helper.
package reg_file_bank_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int NUM_REGS     = 8;
    localparam int DEF_PC_INDEX = 7;

    // True when more than one bit of the (active-high) select vector is set.
    function automatic logic more_than_one(input logic [NUM_REGS-1:0] v);
        int cnt;
        cnt = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return (cnt > 1);
    endfunction

endpackage

// File: rtl/reg_file_bank_if.sv
// Register-select bus between the selector/microsequencer (master) and the register file (slave).
// Strobes are active-low and are sampled on the rising clock edge; outputs are combinational.
interface reg_file_bank_if
    import reg_file_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [NUM_REGS-1:0] regNotOEs;
    logic [NUM_REGS-1:0] regNotLoads;
    logic [WIDTH-1:0]    dataIn;
    logic                pcInc;
    logic                errClear;
    logic [2:0]          dbgSel;
    logic [WIDTH-1:0]    dataOut;
    logic                busDriven;
    logic                oeConflict;
    logic                loadConflict;
    logic [WIDTH-1:0]    dbgData;

    modport master (
        output regNotOEs, regNotLoads, dataIn, pcInc, errClear, dbgSel,
        input  dataOut, busDriven, oeConflict, loadConflict, dbgData
    );

    modport slave (
        input  regNotOEs, regNotLoads, dataIn, pcInc, errClear, dbgSel,
        output dataOut, busDriven, oeConflict, loadConflict, dbgData
    );
endinterface

// File: rtl/reg_file_bank_reg_cell.sv
// One WIDTH-bit register: synchronous reset value, load, and increment.
// Load has priority over increment so a bus write to the PC drops a pending increment.
module reg_cell #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= RESET_VAL;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_inc) begin
            r_q <= r_q + ONE;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/reg_file_bank.sv
// Eight-register file driven by active-low OE/load strobes, with a wired-OR read bus,
// an incrementing program-counter register and sticky strobe-conflict flags.
module reg_file_bank
    import reg_file_bank_pkg::*;
#(
    parameter int               WIDTH    = DEF_WIDTH,
    parameter int               PC_INDEX = DEF_PC_INDEX,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clock,
    input  logic           reset,
    reg_file_bank_if.slave rf
);
    logic [WIDTH-1:0] w_q [NUM_REGS];
    logic [WIDTH-1:0] w_bus;
    logic             r_oe_conflict;
    logic             r_load_conflict;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_cell
        localparam logic [WIDTH-1:0] CELL_RST = (gi == PC_INDEX) ? RESET_PC : '0;
        logic w_inc;

        if (gi == PC_INDEX) begin : g_pc
            assign w_inc = rf.pcInc;
        end else begin : g_plain
            assign w_inc = 1'b0;
        end

        reg_cell #(
            .WIDTH     (WIDTH),
            .RESET_VAL (CELL_RST)
        ) u_cell (
            .clock  (clock),
            .reset  (reset),
            .i_load (~rf.regNotLoads[gi]),
            .i_inc  (w_inc),
            .i_data (rf.dataIn),
            .o_q    (w_q[gi])
        );
    end

    // Wired-OR bus: every enabled register contributes; nothing enabled reads as zero.
    always_comb begin
        w_bus = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (!rf.regNotOEs[i]) begin
                w_bus = w_bus | w_q[i];
            end
        end
    end

    // Sticky flags: a new conflict wins over a simultaneous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_oe_conflict   <= 1'b0;
            r_load_conflict <= 1'b0;
        end else begin
            r_oe_conflict   <= more_than_one(~rf.regNotOEs)
                               | (r_oe_conflict & ~rf.errClear);
            r_load_conflict <= more_than_one(~rf.regNotLoads)
                               | (r_load_conflict & ~rf.errClear);
        end
    end

    assign rf.dataOut      = w_bus;
    assign rf.busDriven    = ~&rf.regNotOEs;
    assign rf.oeConflict   = r_oe_conflict;
    assign rf.loadConflict = r_load_conflict;
    assign rf.dbgData      = w_q[rf.dbgSel];
endmodule

// File: tb/tb_reg_file_bank.sv
// Directed bench for reg_file_bank: reset, load/read, PC increment, conflict flags,
// read-while-load and reset during activity.
module tb_reg_file_bank;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    reg_file_bank_if #(.WIDTH(16)) bus_if ();

    reg_file_bank #(
        .WIDTH    (16),
        .PC_INDEX (7),
        .RESET_PC (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .rf    (bus_if.slave)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    // Advance one rising edge; inputs change and checks happen 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus_if.dataIn      = 16'hBEEF;
        bus_if.regNotLoads = 8'h00;
        bus_if.regNotOEs   = 8'hFF;
        bus_if.pcInc       = 1'b0;
        bus_if.errClear    = 1'b0;
        bus_if.dbgSel      = 3'd0;
        tick();
        tick();
        reset              = 1'b0;
        bus_if.regNotLoads = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            bus_if.dbgSel = i[2:0];
            #1;
            checks++;
            if (bus_if.dbgData !== 16'h0000) begin
                errors++;
                $display("FAIL reset_reg%0d got %h exp 0000", i, bus_if.dbgData);
            end
        end
        checks++;
        if (bus_if.oeConflict !== 1'b0 || bus_if.loadConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got oe=%b ld=%b exp 0 0", bus_if.oeConflict, bus_if.loadConflict);
        end
        checks++;
        if (bus_if.busDriven !== 1'b0 || bus_if.dataOut !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus got drv=%b out=%h exp 0 0000", bus_if.busDriven, bus_if.dataOut);
        end
    endtask

    task automatic test_load_read();
        logic [15:0] exp;
        bus_if.regNotLoads = 8'hF7;
        bus_if.dataIn      = 16'h1234;
        tick();
        bus_if.regNotLoads = 8'hFF;
        bus_if.regNotOEs   = 8'hF7;
        #1;
        checks++;
        if (bus_if.dataOut !== 16'h1234 || bus_if.busDriven !== 1'b1) begin
            errors++;
            $display("FAIL load_read_bus got out=%h drv=%b exp 1234 1", bus_if.dataOut, bus_if.busDriven);
        end
        for (int i = 0; i < 8; i++) begin
            bus_if.dbgSel = i[2:0];
            exp = (i == 3) ? 16'h1234 : 16'h0000;
            #1;
            checks++;
            if (bus_if.dbgData !== exp) begin
                errors++;
                $display("FAIL load_read_reg%0d got %h exp %h", i, bus_if.dbgData, exp);
            end
        end
        bus_if.regNotOEs = 8'hFF;
    endtask

    task automatic test_pc_inc();
        bus_if.dbgSel      = 3'd7;
        bus_if.regNotLoads = 8'h7F;
        bus_if.dataIn      = 16'hFFFE;
        tick();
        bus_if.regNotLoads = 8'hFF;
        bus_if.pcInc       = 1'b1;
        tick();
        checks++;
        if (bus_if.dbgData !== 16'hFFFF) begin
            errors++;
            $display("FAIL pc_inc1 got %h exp FFFF", bus_if.dbgData);
        end
        tick();
        checks++;
        if (bus_if.dbgData !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap got %h exp 0000", bus_if.dbgData);
        end
        bus_if.regNotLoads = 8'h7F;
        bus_if.dataIn      = 16'h0100;
        tick();
        bus_if.regNotLoads = 8'hFF;
        bus_if.pcInc       = 1'b0;
        checks++;
        if (bus_if.dbgData !== 16'h0100) begin
            errors++;
            $display("FAIL pc_load_wins got %h exp 0100", bus_if.dbgData);
        end
        bus_if.dbgSel = 3'd3;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'h1234) begin
            errors++;
            $display("FAIL pc_inc_isolated got %h exp 1234", bus_if.dbgData);
        end
    endtask

    task automatic test_oe_conflict();
        bus_if.regNotLoads = 8'hFD;
        bus_if.dataIn      = 16'h00F0;
        tick();
        bus_if.regNotLoads = 8'hFB;
        bus_if.dataIn      = 16'h0F00;
        tick();
        bus_if.regNotLoads = 8'hFF;
        bus_if.regNotOEs   = 8'hF9;
        #1;
        checks++;
        if (bus_if.dataOut !== 16'h0FF0 || bus_if.busDriven !== 1'b1) begin
            errors++;
            $display("FAIL oe_wired_or got out=%h drv=%b exp 0FF0 1", bus_if.dataOut, bus_if.busDriven);
        end
        checks++;
        if (bus_if.oeConflict !== 1'b0) begin
            errors++;
            $display("FAIL oe_before_edge got %b exp 0", bus_if.oeConflict);
        end
        tick();
        checks++;
        if (bus_if.oeConflict !== 1'b1 || bus_if.loadConflict !== 1'b0) begin
            errors++;
            $display("FAIL oe_set got oe=%b ld=%b exp 1 0", bus_if.oeConflict, bus_if.loadConflict);
        end
        bus_if.regNotOEs = 8'hFF;
        tick();
        checks++;
        if (bus_if.oeConflict !== 1'b1) begin
            errors++;
            $display("FAIL oe_sticky got %b exp 1", bus_if.oeConflict);
        end
        bus_if.errClear = 1'b1;
        tick();
        bus_if.errClear = 1'b0;
        checks++;
        if (bus_if.oeConflict !== 1'b0) begin
            errors++;
            $display("FAIL oe_clear got %b exp 0", bus_if.oeConflict);
        end
    endtask

    task automatic test_load_conflict();
        bus_if.regNotLoads = 8'h3F;
        bus_if.dataIn      = 16'hA5A5;
        tick();
        bus_if.regNotLoads = 8'hFF;
        bus_if.dbgSel      = 3'd6;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'hA5A5) begin
            errors++;
            $display("FAIL multi_load_reg6 got %h exp A5A5", bus_if.dbgData);
        end
        bus_if.dbgSel = 3'd7;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'hA5A5) begin
            errors++;
            $display("FAIL multi_load_reg7 got %h exp A5A5", bus_if.dbgData);
        end
        bus_if.dbgSel = 3'd5;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'h0000) begin
            errors++;
            $display("FAIL multi_load_reg5 got %h exp 0000", bus_if.dbgData);
        end
        checks++;
        if (bus_if.loadConflict !== 1'b1 || bus_if.oeConflict !== 1'b0) begin
            errors++;
            $display("FAIL load_conf_set got ld=%b oe=%b exp 1 0", bus_if.loadConflict, bus_if.oeConflict);
        end
        bus_if.errClear    = 1'b1;
        bus_if.regNotLoads = 8'hFC;
        tick();
        bus_if.errClear    = 1'b0;
        bus_if.regNotLoads = 8'hFF;
        checks++;
        if (bus_if.loadConflict !== 1'b1) begin
            errors++;
            $display("FAIL load_set_wins got %b exp 1", bus_if.loadConflict);
        end
        bus_if.errClear = 1'b1;
        tick();
        bus_if.errClear = 1'b0;
        checks++;
        if (bus_if.loadConflict !== 1'b0) begin
            errors++;
            $display("FAIL load_clear got %b exp 0", bus_if.loadConflict);
        end
    endtask

    task automatic test_read_write_same();
        bus_if.regNotLoads = 8'hEF;
        bus_if.dataIn      = 16'h5555;
        tick();
        bus_if.regNotOEs = 8'hEF;
        bus_if.dataIn    = 16'hAAAA;
        #1;
        checks++;
        if (bus_if.dataOut !== 16'h5555) begin
            errors++;
            $display("FAIL rw_old_value got %h exp 5555", bus_if.dataOut);
        end
        tick();
        bus_if.regNotLoads = 8'hFF;
        checks++;
        if (bus_if.dataOut !== 16'hAAAA) begin
            errors++;
            $display("FAIL rw_new_value got %h exp AAAA", bus_if.dataOut);
        end
    endtask

    task automatic test_reset_mid();
        reset              = 1'b1;
        bus_if.regNotLoads = 8'hEF;
        bus_if.dataIn      = 16'h1111;
        bus_if.pcInc       = 1'b1;
        bus_if.regNotOEs   = 8'hEE;
        tick();
        reset              = 1'b0;
        bus_if.regNotLoads = 8'hFF;
        bus_if.pcInc       = 1'b0;
        checks++;
        if (bus_if.dataOut !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_bus got %h exp 0000", bus_if.dataOut);
        end
        checks++;
        if (bus_if.oeConflict !== 1'b0 || bus_if.loadConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_flags got oe=%b ld=%b exp 0 0", bus_if.oeConflict, bus_if.loadConflict);
        end
        bus_if.regNotOEs = 8'hFF;
        bus_if.dbgSel    = 3'd4;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_reg4 got %h exp 0000", bus_if.dbgData);
        end
        bus_if.dbgSel = 3'd7;
        #1;
        checks++;
        if (bus_if.dbgData !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_pc got %h exp 0000", bus_if.dbgData);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_read();
        test_pc_inc();
        test_oe_conflict();
        test_load_conflict();
        test_read_write_same();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
